// File: rtl/es_mem_req_unit.sv
// rtl/es_mem_req_unit.sv - execute-stage load/store request issuer for the SRAM-like data bus
// Holds one instruction, flags misalignment, drives req/addr/wstrb/wdata and counts outstanding requests.
module es_mem_req_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  localparam int SB = DATA_W / 8,
  localparam int OW = $clog2(SB)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_kill,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ale,
  output logic              out_issued,
  output logic [OW-1:0]     out_offs,
  output logic [2:0]        outstanding,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [SB-1:0]     wstrb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic                load_q, load_d;
  logic                store_q, store_d;
  logic                kill_q, kill_d;
  logic                ale_q, ale_d;
  logic                issued_q, issued_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SB-1:0]       wstrb_q, wstrb_d;
  logic [2:0]          outst_q, outst_d;

  logic [OW-1:0]       in_offs;
  logic                in_ale;
  logic [SB-1:0]       in_strb;
  logic [DATA_W-1:0]   in_rep;
  logic                req_c;
  logic                hs;
  logic                dec;
  logic                take;

  assign in_offs = in_addr[OW-1:0];

  // Strobe, replication and misalignment of the incoming instruction, captured on acceptance.
  always_comb begin
    in_ale  = 1'b0;
    in_strb = '0;
    in_rep  = '0;
    case (in_size)
      2'd0: in_strb = SB'(1) << in_offs;
      2'd1: begin
        in_ale  = in_addr[0];
        in_strb = SB'(3) << in_offs;
      end
      2'd2: begin
        in_ale  = |in_addr[1:0];
        in_strb = SB'(4'hF) << (in_offs & ~OW'(3));
      end
      default: begin
        in_ale  = (DATA_W != 64) | (|in_addr[2:0]);
        in_strb = '1;
      end
    endcase
    for (int i = 0; i < SB; i++) begin
      case (in_size)
        2'd0:    in_rep[8*i +: 8] = in_wdata[7:0];
        2'd1:    in_rep[8*i +: 8] = in_wdata[8*(i%2) +: 8];
        2'd2:    in_rep[8*i +: 8] = in_wdata[8*(i%4) +: 8];
        default: in_rep[8*i +: 8] = in_wdata[8*i +: 8];
      endcase
    end
  end

  // Only this unit raises the count, so req cannot fall once it has risen in ISSUE.
  assign req_c    = (state_q == DRAIN) | ((state_q == ISSUE) & (outst_q < 3'(MAX_OUTST)));
  assign hs       = req_c & addr_ok;
  assign dec      = data_ok & (outst_q != 3'd0);
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign take     = in_valid & in_ready & ~flush;

  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    store_d  = store_q;
    kill_d   = kill_q;
    ale_d    = ale_q;
    issued_d = issued_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    outst_d  = outst_q + 3'(hs) - 3'(dec);

    case (state_q)
      ISSUE: begin
        if (flush) begin
          state_d = (req_c & ~addr_ok) ? DRAIN : IDLE;
        end else if (hs) begin
          state_d  = DONE;
          issued_d = 1'b1;
        end
      end
      DONE:    if (flush | out_ready) state_d = IDLE;
      DRAIN:   if (addr_ok) state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (take) begin
      load_d   = in_load;
      store_d  = in_store;
      kill_d   = in_kill;
      ale_d    = in_ale;
      issued_d = 1'b0;
      size_d   = in_size;
      addr_d   = in_addr;
      wdata_d  = in_rep;
      wstrb_d  = in_store ? in_strb : '0;
      state_d  = ((in_load | in_store) & ~in_kill & ~in_ale) ? ISSUE : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      kill_q   <= 1'b0;
      ale_q    <= 1'b0;
      issued_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      outst_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      store_q  <= store_d;
      kill_q   <= kill_d;
      ale_q    <= ale_d;
      issued_q <= issued_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      outst_q  <= outst_d;
    end
  end

  assign out_valid   = (state_q == DONE);
  assign out_ale     = out_valid & ale_q & (load_q | store_q) & ~kill_q;
  assign out_issued  = out_valid & issued_q;
  assign out_offs    = addr_q[OW-1:0];
  assign outstanding = outst_q;
  assign req         = req_c;
  assign wr          = store_q;
  assign size        = size_q;
  assign wstrb       = wstrb_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;

endmodule

// File: doc/es_mem_req_unit.md
Name: es_mem_req_unit

Overview:
- Parametrised execute-stage memory request issuer for the pipelined CPU, sitting between the EXE datapath and the SRAM-like data bus (req/addr_ok/data_ok).
- Holds one load/store at a time.
- Detects misaligned access (ALE) and builds byte strobes and replicated write data for any power-of-two bus width.
- Keeps the request stable until `addr_ok`, tracks outstanding requests against a configurable limit, and handles pipeline flush without retracting an in-flight request.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data bus width; 32 or 64; strobe width SB = DATA_W/8.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests; range 1..7.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  exception/ertn flush from WB; kills held instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  unit can accept instruction
- in_load  in  1  instruction is a load
- in_store  in  1  instruction is a store
- in_size  in  2  0=byte 1=half 2=word 3=dword (dword legal only when DATA_W=64)
- in_kill  in  1  instruction already carries an exception or a later stage has one; no bus access
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store source, data in low bits
- out_valid  out  1  result for downstream stage valid
- out_ready  in  1  downstream accepts
- out_ale  out  1  address-misaligned exception for held instruction
- out_issued  out  1  held instruction's request was accepted by bus; MEM must wait for data_ok
- out_offs  out  log2(SB)  in_addr low bits, for load extraction in MEM
- outstanding  out  3  current outstanding count
- req  out  1  bus request
- wr  out  1  1=store
- size  out  2  registered in_size
- wstrb  out  SB  byte enables (all 0 for loads)
- addr  out  ADDR_W  full unaligned address
- wdata  out  DATA_W  replicated store data
- addr_ok  in  1  bus accepted request this cycle
- data_ok  in  1  bus returned a response (any earlier request)

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE, outstanding=0.
  - All outputs 0 except in_ready=1.
  - Held registers cleared.
- States:
  - IDLE: empty.
  - ISSUE: memory op holding req.
  - DONE: result waiting for out_ready.
  - DRAIN: flushed while req was high.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- On in_valid & in_ready, latch all in_* fields. Next state:
  - ISSUE if (in_load|in_store) & ~in_kill & ~ale.
  - DONE otherwise (non-mem instruction, killed, or ALE; no bus access, out_issued=0).
- ALE = misalignment: half & a[0]; word & |a[1:0]; dword & |a[2:0].
  - out_ale = held_ale & (in_load|in_store) & ~in_kill.
  - Illegal size 3 with DATA_W=32 counts as ALE.
- ISSUE:
  - req = (outstanding < MAX_OUTST).
  - req, wr, size, addr, wstrb, wdata come from registers and are stable every cycle of ISSUE.
  - On req & addr_ok: outstanding+1, out_issued set, go to DONE. No bubble: the result is presented the next cycle.
  - Once req has been 1 it stays 1 until addr_ok, even if later outstanding changes.
- wstrb:
  - byte: one-hot at offs.
  - half: 2'b11 << offs.
  - word: 4'hF << (offs aligned to 4).
  - dword: all ones.
- wdata:
  - byte: replicated SB times.
  - half: replicated SB/2 times.
  - word: replicated DATA_W/32 times.
  - dword: as is.
- DONE: out_valid=1. On out_ready, either go to IDLE or load a new instruction in the same cycle (back-to-back, one instruction per cycle when there is no bus stall).
- outstanding:
  - +1 on req&addr_ok, −1 on data_ok; both in the same cycle leaves it unchanged.
  - data_ok with outstanding==0 is ignored and must not underflow.
- flush (priority over everything except reset):
  - IDLE/DONE: go to IDLE, out_valid drops next cycle, latched op discarded.
  - ISSUE with req=0 this cycle: go to IDLE, no bus access.
  - ISSUE with req=1 and no addr_ok: go to DRAIN; req stays asserted with the same fields until addr_ok, then IDLE. outstanding increments normally (MEM discards the response). in_ready=0 and out_valid=0 in DRAIN.
  - ISSUE with req=1 & addr_ok same cycle: count increments, go to IDLE.
  - in_valid during a flush cycle is not accepted.

Test Plan:
- DATA_W=32: sw addr 0x1000, wdata 0x11223344; addr_ok low 2 cycles -> req high 3 cycles with stable wstrb=4'hF, wdata=0x11223344; out_valid in the cycle after addr_ok; outstanding=1; data_ok -> 0.
- st.b addr 0x2003, wdata 0x000000AB -> wstrb=4'b1000, wdata=0xABABABAB, addr=0x2003; st.h addr 0x2002, data 0xBEEF -> wstrb=4'b1100, wdata=0xBEEFBEEF.
- ld.w addr 0x3001 -> no req ever; out_valid next cycle with out_ale=1, out_issued=0. Same with in_kill=1 -> out_ale=0, no req.
- MAX_OUTST=2: two loads accepted with no data_ok -> third load holds req=0 and stalls; data_ok pulse -> req rises next cycle. Simultaneous addr_ok+data_ok keeps count constant.
- Flush while req=1 and addr_ok withheld 3 cycles -> state DRAIN, req and addr held stable, out_valid never asserts; addr_ok -> IDLE and outstanding=1. Flush in DONE -> out_valid drops, no bus activity.
- DATA_W=64: st.w addr 0x4004 data 0xCAFEF00D -> wstrb=8'hF0, wdata=0xCAFEF00DCAFEF00D; ld.d addr 0x4004 -> out_ale=1. Reset mid-ISSUE -> req=0 and outstanding=0 next cycle.
